// File: rtl/rom_seq_reader_pkg.sv
// rom_seq_pkg: shared widths, buffer sizing, FSM state type and the issue-credit helper
// for rom_seq_reader and its output FIFO.
package rom_seq_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 5;
    localparam int unsigned ROM_DEPTH = 10;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned ROM_LAT   = 1;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // A new issue is allowed only if every word already owed to the buffer still fits.
    function automatic logic has_credit(input logic [CNT_W-1:0] count,
                                        input logic             issued,
                                        input logic             romdata);
        logic [CNT_W:0] sum;
        sum = {1'b0, count} + {{CNT_W{1'b0}}, issued} + {{CNT_W{1'b0}}, romdata};
        return sum < (CNT_W + 1)'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/rom_seq_reader_if.sv
// rom_seq_reader_if: control, ROM and downstream handshake signals of rom_seq_reader.
// master = environment side (drives requests, ROM data, out_ready); slave = the reader.
interface rom_seq_reader_if;
    import rom_seq_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_d;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, first_addr, last_addr, stop, rom_d, out_ready,
        input  rom_addr, out_data, out_valid, busy, done, err
    );

    modport slave (
        input  start, first_addr, last_addr, stop, rom_d, out_ready,
        output rom_addr, out_data, out_valid, busy, done, err
    );

endinterface

// File: rtl/rom_seq_fifo.sv
// rom_seq_fifo: BUF_DEPTH-entry synchronous FIFO holding ROM words for downstream.
// Head entry is storage, so data_o is a registered value; storage resets to zero.
module rom_seq_fifo
    import rom_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    // Gate requests against the current occupancy.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CNT_W'(BUF_DEPTH));
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        data_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rom_seq_reader.sv
// rom_seq_reader: on start, walks first_addr..last_addr through a 1-cycle-latency ROM and
// delivers each word over valid/ready. Issue is credit-limited so words are never dropped.
// Optional macro ROM_SEQ_LOOP_EN: wrap from last_addr back to first_addr until stop.
module rom_seq_reader
    import rom_seq_pkg::*;
#(
    parameter int unsigned RomDepth = ROM_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    rom_seq_reader_if.slave bus
);

`ifdef ROM_SEQ_LOOP_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] rom_addr_q, next_addr_q, first_q, last_q;
    logic              issued_q, romdata_q, busy_q, done_q, err_q;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              range_ok, issue_en, at_last, drain_done;
    logic [ADDR_W-1:0] issue_addr, wrap_addr;

    // Decide whether an address goes to the ROM this cycle and which one.
    always_comb begin
        range_ok   = (bus.first_addr <= bus.last_addr) && (bus.last_addr < ADDR_W'(RomDepth));
        issue_en   = 1'b0;
        issue_addr = next_addr_q;
        at_last    = (next_addr_q == last_q);
        wrap_addr  = first_q;
        unique case (state_q)
            StIdle: begin
                issue_en   = bus.start && range_ok;
                issue_addr = bus.first_addr;
                at_last    = (bus.first_addr == bus.last_addr);
                wrap_addr  = bus.first_addr;
            end
            StRun: begin
                issue_en = !fifo_full && has_credit(fifo_count, issued_q, romdata_q);
            end
            default: ;
        endcase
        fifo_pop   = !fifo_empty && bus.out_ready;
        // Done fires on the edge that hands off the final buffered word.
        drain_done = !issued_q && !romdata_q &&
                     (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));
    end

    // Sequencer FSM with registered status outputs and ROM latency tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rom_addr_q  <= '0;
            next_addr_q <= '0;
            first_q     <= '0;
            last_q      <= '0;
            issued_q    <= 1'b0;
            romdata_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            issued_q  <= issue_en;
            romdata_q <= issued_q;
            if (issue_en) begin
                rom_addr_q  <= issue_addr;
                next_addr_q <= at_last ? wrap_addr : issue_addr + ADDR_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start && range_ok) begin
                        first_q <= bus.first_addr;
                        last_q  <= bus.last_addr;
                        busy_q  <= 1'b1;
                        state_q <= (at_last && !LoopEn) ? StDrain : StRun;
                    end else if (bus.start) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end
                end
                StRun: begin
                    // A same-cycle stop still lets this cycle's issue complete.
                    if (bus.stop || (issue_en && at_last && !LoopEn)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rom_seq_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (romdata_q),
        .data_i  (bus.rom_d),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_data  = fifo_data;
    assign bus.out_valid = !fifo_empty;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
